// File: rtl/mips_defs_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds the ALU operation codes driven on ALUctr, the opcode and funct
// encodings the controller recognises, and the controller state type.
package mips_defs_pkg;

    // ALU operation codes
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0111;
    localparam logic [3:0] AluLui = 4'b1010;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FunctAdd  = 6'b100000;
    localparam logic [5:0] FunctAddu = 6'b100001;
    localparam logic [5:0] FunctSub  = 6'b100010;
    localparam logic [5:0] FunctSubu = 6'b100011;
    localparam logic [5:0] FunctAnd  = 6'b100100;
    localparam logic [5:0] FunctOr   = 6'b100101;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StRExec,
        StRWb,
        StIExec,
        StIWb,
        StBranch,
        StJump
    } state_e;

endpackage

// File: rtl/mips_alu_dec.sv
// ALU control decoder for the multicycle MIPS controller.
// Maps the current controller state plus op/funct onto the ALU operation and
// immediate extension mode, and reports whether op/funct is a supported
// instruction.
//   state_i    : current controller state
//   op_i       : IR[31:26]
//   funct_i    : IR[5:0]
//   alu_ctr_o  : ALU operation code (add unless the state needs otherwise)
//   ext_op_o   : 1 = sign-extend immediate, 0 = zero-extend
//   op_legal_o : op (and funct for R-type) is supported
module mips_alu_dec
    import mips_defs_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctr_o,
    output logic       ext_op_o,
    output logic       op_legal_o
);

    logic [3:0] r_ctr;
    logic       r_legal;
    logic [3:0] i_ctr;
    logic       i_ext;

    // R-type funct decode
    always_comb begin
        r_ctr   = AluAdd;
        r_legal = 1'b1;
        case (funct_i)
            FunctAdd, FunctAddu: r_ctr = AluAdd;
            FunctSub, FunctSubu: r_ctr = AluSub;
            FunctAnd:            r_ctr = AluAnd;
            FunctOr:             r_ctr = AluOr;
            default:             r_legal = 1'b0;
        endcase
    end

    // I-type op decode; logical immediates are zero-extended
    always_comb begin
        i_ctr = AluAdd;
        i_ext = 1'b1;
        case (op_i)
            OpOri: begin
                i_ctr = AluOr;
                i_ext = 1'b0;
            end
            OpLui: begin
                i_ctr = AluLui;
                i_ext = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        op_legal_o = 1'b0;
        case (op_i)
            OpRType:                                      op_legal_o = r_legal;
            OpLw, OpSw, OpAddiu, OpOri, OpLui, OpBeq, OpJ: op_legal_o = 1'b1;
            default:                                      op_legal_o = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctr_o = AluAdd;
        ext_op_o  = 1'b0;
        case (state_i)
            StDecode, StMemAddr: ext_op_o = 1'b1;
            StRExec:             alu_ctr_o = r_ctr;
            StIExec: begin
                alu_ctr_o = i_ctr;
                ext_op_o  = i_ext;
            end
            StBranch:            alu_ctr_o = AluSub;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM.
// Sequences fetch/decode/execute/memory/writeback and drives the ALU control,
// datapath selects and write enables. Memory states wait for mem_rdy with a
// bounded wait counter; a timeout raises bus_err and abandons the instruction.
//   clk, rst        : clock, asynchronous active-high reset
//   op, funct, zero : IR fields and ALU zero flag
//   mem_rdy         : memory access complete this cycle
//   ALUctr, alu_src_a, alu_src_b, ext_op           : ALU control
//   pc_we, pc_src, iord, mem_req, mem_we, ir_we    : PC / memory / IR control
//   reg_we, reg_dst, mem_to_reg                    : register file control
//   illegal, bus_err                               : single-cycle error pulses
module mips_mc_ctrl
    import mips_defs_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 16,
    parameter int unsigned WAIT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic [3:0] ALUctr,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic       bus_err
);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              in_mem;
    logic              timeout;
    logic              op_legal;
    logic [3:0]        dec_alu_ctr;
    logic              dec_ext_op;

    mips_alu_dec u_alu_dec (
        .state_i    (state_q),
        .op_i       (op),
        .funct_i    (funct),
        .alu_ctr_o  (dec_alu_ctr),
        .ext_op_o   (dec_ext_op),
        .op_legal_o (op_legal)
    );

    assign in_mem  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout = in_mem && !mem_rdy && (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX));

    // Every non-waiting cycle leaves the counter at zero, so entry into a
    // memory state always starts a fresh count.
    always_comb begin
        wait_cnt_d = '0;
        if (in_mem && !mem_rdy && !timeout) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                if (mem_rdy) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StFetch;
                if (op_legal) begin
                    case (op)
                        OpLw, OpSw:            state_d = StMemAddr;
                        OpRType:               state_d = StRExec;
                        OpAddiu, OpOri, OpLui: state_d = StIExec;
                        OpBeq:                 state_d = StBranch;
                        OpJ:                   state_d = StJump;
                        default:               state_d = StFetch;
                    endcase
                end
            end
            StMemAddr: state_d = (op == OpSw) ? StMemWr : StMemRd;
            StMemRd: begin
                if (mem_rdy) begin
                    state_d = StMemWb;
                end else if (timeout) begin
                    state_d = StFetch;
                end
            end
            StMemWr: begin
                if (mem_rdy || timeout) begin
                    state_d = StFetch;
                end
            end
            StRExec:  state_d = StRWb;
            StIExec:  state_d = StIWb;
            StMemWb, StRWb, StIWb, StBranch, StJump: state_d = StFetch;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ALUctr     = dec_alu_ctr;
        ext_op     = dec_ext_op;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        bus_err    = timeout;
        case (state_q)
            StFetch: begin
                mem_req   = !timeout;
                alu_src_b = 2'b01;
                ir_we     = mem_rdy;
                pc_we     = mem_rdy;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                illegal   = !op_legal;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_req = !timeout;
                iord    = 1'b1;
            end
            StMemWb: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_req = !timeout;
                mem_we  = !timeout;
                iord    = 1'b1;
            end
            StRExec: alu_src_a = 1'b1;
            StRWb: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StIWb:   reg_we = 1'b1;
            StBranch: begin
                alu_src_a = 1'b1;
                pc_src    = 2'b01;
                pc_we     = zero;
            end
            StJump: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule
